// File: rtl/bhg_display_rmem_pkg.sv
// rtl/bhg_display_rmem_pkg.sv - shared types and helpers for the multi-layer raster read generator
package bhg_display_rmem_pkg;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    typedef struct packed {
        logic        ena;
        logic [2:0]  pixel_bytes;
        logic [31:0] mem_addr;
        logic [15:0] bitmap_width;
        logic [13:0] xpos;
        logic [13:0] ypos;
    } layer_cfg_t;

    // Unsupported pixel sizes fall back to 1 byte per pixel.
    function automatic logic [1:0] pixel_shift(input logic [2:0] pixel_bytes);
        case (pixel_bytes)
            3'd2:    return 2'd1;
            3'd4:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/bhg_sync_edge.sv
// rtl/bhg_sync_edge.sv - two-flop synchroniser with rising-edge detect
module bhg_sync_edge (
    input  logic CMD_CLK,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge CMD_CLK) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/bhg_display_rmem_ml.sv
// rtl/bhg_display_rmem_ml.sv - per-line DDR3 read request generator for up to LAYERS bitmaps
module bhg_display_rmem_ml
    import bhg_display_rmem_pkg::*;
#(
    parameter int PORT_ADDR_SIZE    = 24,
    parameter int PORT_VECTOR_SIZE  = 12,
    parameter int PORT_R_DATA_WIDTH = 128,
    parameter int LAYERS            = 2,
    parameter int LB_WORD_BITS      = 9
) (
    input  logic                        CMD_CLK,
    input  logic                        reset,
    input  logic [LAYERS-1:0]           DISP_layer_ena,
    input  logic [LAYERS*3-1:0]         DISP_pixel_bytes,
    input  logic [LAYERS*32-1:0]        DISP_mem_addr,
    input  logic [LAYERS*16-1:0]        DISP_bitmap_width,
    input  logic [LAYERS*14-1:0]        DISP_xpos,
    input  logic [LAYERS*14-1:0]        DISP_ypos,
    input  logic [13:0]                 DISP_xsize,
    input  logic                        read_busy_in,
    output logic                        read_req_out,
    output logic [PORT_ADDR_SIZE-1:0]   read_adr_out,
    output logic [PORT_VECTOR_SIZE-1:0] read_line_mem_adr,
    input  logic                        VID_xena_in,
    input  logic                        VID_yena_in,
    output logic [LAYERS*2-1:0]         VID_xpos_out,
    output logic                        VID_ypos_out,
    output logic                        line_overrun_out
);

    localparam int WORD_BYTES = PORT_R_DATA_WIDTH / 8;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
    localparam int LAYER_BITS = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int REM_BITS   = LB_WORD_BITS + 1;
    localparam logic [16:0] REM_CAP = 17'(1 << LB_WORD_BITS);

    logic hs, yena, xena_q;

    bhg_sync_edge u_sync_x (.CMD_CLK(CMD_CLK), .reset(reset), .d(VID_xena_in), .q(xena_q), .rise(hs));
    bhg_sync_edge u_sync_y (.CMD_CLK(CMD_CLK), .reset(reset), .d(VID_yena_in), .q(yena), .rise());

    layer_cfg_t cfg [LAYERS];

    always_comb begin
        for (int l = 0; l < LAYERS; l++) begin
            cfg[l].ena          = DISP_layer_ena[l];
            cfg[l].pixel_bytes  = DISP_pixel_bytes[l*3 +: 3];
            cfg[l].mem_addr     = DISP_mem_addr[l*32 +: 32];
            cfg[l].bitmap_width = DISP_bitmap_width[l*16 +: 16];
            cfg[l].xpos         = DISP_xpos[l*14 +: 14];
            cfg[l].ypos         = DISP_ypos[l*14 +: 14];
        end
    end

    state_t                    state;
    logic [LAYER_BITS-1:0]     cur_l;
    logic                      half;
    logic [11:0]               rast_y;
    logic [PORT_ADDR_SIZE-1:0] adr;
    logic [REM_BITS-1:0]       rem;
    logic [LB_WORD_BITS-1:0]   word;
    logic [PORT_ADDR_SIZE-1:0] ptr       [LAYERS];
    logic [15:0]               lat_width [LAYERS];
    logic [1:0]                lat_shift [LAYERS];

    logic [LAYER_BITS-1:0]     first_l, next_l, setup_l;
    logic                      first_found, next_found, do_setup;
    logic [29:0]               prod;
    logic [31:0]               calc_sum;
    logic [15:0]               xs_bytes;
    logic [16:0]               wcnt;
    logic [REM_BITS-1:0]       setup_rem, rem_next;
    logic [PORT_ADDR_SIZE-1:0] setup_stride;

    always_comb begin
        first_l     = '0;
        first_found = 1'b0;
        next_l      = '0;
        next_found  = 1'b0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (cfg[i].ena) begin
                first_l     = LAYER_BITS'(i);
                first_found = 1'b1;
            end
            if (cfg[i].ena && i > int'(cur_l)) begin
                next_l     = LAYER_BITS'(i);
                next_found = 1'b1;
            end
        end
    end

    // The single multiplier is shared across layers: CALC walks cur_l one layer per cycle.
    always_comb begin
        prod     = 30'(cfg[cur_l].bitmap_width) * 30'(cfg[cur_l].ypos);
        calc_sum = cfg[cur_l].mem_addr
                 + ((32'(prod) + 32'(cfg[cur_l].xpos)) << pixel_shift(cfg[cur_l].pixel_bytes));
    end

    always_comb begin
        rem_next     = rem - REM_BITS'(read_req_out);
        setup_l      = hs ? first_l : next_l;
        do_setup     = hs ? (yena && first_found)
                          : (state == ISSUE && rem_next == '0 && next_found);
        xs_bytes     = {2'b00, DISP_xsize} << lat_shift[setup_l];
        wcnt         = 17'(xs_bytes >> WORD_SHIFT) + 17'd1;
        setup_rem    = (wcnt > REM_CAP) ? REM_BITS'(REM_CAP) : REM_BITS'(wcnt);
        setup_stride = PORT_ADDR_SIZE'(32'(lat_width[setup_l]) << lat_shift[setup_l]);
    end

    always_ff @(posedge CMD_CLK) begin
        if (reset) begin
            state            <= IDLE;
            cur_l            <= '0;
            half             <= 1'b0;
            rast_y           <= '0;
            adr              <= '0;
            rem              <= '0;
            word             <= '0;
            read_req_out     <= 1'b0;
            line_overrun_out <= 1'b0;
            VID_ypos_out     <= 1'b0;
            VID_xpos_out     <= '0;
            for (int l = 0; l < LAYERS; l++) begin
                ptr[l]       <= '0;
                lat_width[l] <= '0;
                lat_shift[l] <= '0;
            end
        end else begin
            VID_ypos_out     <= rast_y[0];
            line_overrun_out <= hs && (state != IDLE);
            read_req_out     <= 1'b0;
            if (hs) begin
                if (!yena) begin
                    rast_y <= '0;
                    cur_l  <= '0;
                    state  <= CALC;
                    for (int l = 0; l < LAYERS; l++)
                        VID_xpos_out[l*2 +: 2] <= cfg[l].xpos[1:0];
                end else begin
                    rast_y <= rast_y + 12'd1;
                    half   <= ~rast_y[0];
                    state  <= first_found ? ISSUE : IDLE;
                end
            end else begin
                case (state)
                    CALC: begin
                        ptr[cur_l]       <= calc_sum[PORT_ADDR_SIZE-1:0];
                        lat_width[cur_l] <= cfg[cur_l].bitmap_width;
                        lat_shift[cur_l] <= pixel_shift(cfg[cur_l].pixel_bytes);
                        if (cur_l == LAYER_BITS'(LAYERS - 1))
                            state <= IDLE;
                        else
                            cur_l <= cur_l + 1'b1;
                    end
                    ISSUE: begin
                        if (read_req_out) begin
                            adr  <= adr + PORT_ADDR_SIZE'(WORD_BYTES);
                            word <= word + 1'b1;
                        end
                        rem <= rem_next;
                        if (rem_next == '0) begin
                            if (!next_found)
                                state <= IDLE;
                        end else begin
                            read_req_out <= ~read_busy_in;
                        end
                    end
                    default: ;
                endcase
            end
            // Entering a layer overrides the ISSUE bookkeeping of the layer just finished.
            if (do_setup) begin
                cur_l        <= setup_l;
                adr          <= ptr[setup_l];
                ptr[setup_l] <= ptr[setup_l] + setup_stride;
                rem          <= setup_rem;
                word         <= '0;
            end
        end
    end

    assign read_adr_out      = adr;
    assign read_line_mem_adr = PORT_VECTOR_SIZE'({cur_l, half, word});

endmodule

// File: tb/tb_bhg_display_rmem_ml.sv
// tb/tb_bhg_display_rmem_ml.sv - scoreboard bench for bhg_display_rmem_ml
module tb_bhg_display_rmem_ml;

    logic        CMD_CLK = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ena = '0;
    logic [5:0]  pb = '0;
    logic [63:0] mem = '0;
    logic [31:0] bw = '0;
    logic [27:0] xp = '0, yp = '0;
    logic [13:0] xsize = '0;
    logic        busy = 1'b0;
    logic        xena = 1'b0, yena = 1'b0;
    logic        read_req_out, VID_ypos_out, line_overrun_out;
    logic [23:0] read_adr_out;
    logic [11:0] read_line_mem_adr;
    logic [3:0]  VID_xpos_out;

    always #5 CMD_CLK = ~CMD_CLK;

    bhg_display_rmem_ml dut (
        .CMD_CLK(CMD_CLK), .reset(reset),
        .DISP_layer_ena(ena), .DISP_pixel_bytes(pb), .DISP_mem_addr(mem),
        .DISP_bitmap_width(bw), .DISP_xpos(xp), .DISP_ypos(yp), .DISP_xsize(xsize),
        .read_busy_in(busy), .read_req_out(read_req_out), .read_adr_out(read_adr_out),
        .read_line_mem_adr(read_line_mem_adr), .VID_xena_in(xena), .VID_yena_in(yena),
        .VID_xpos_out(VID_xpos_out), .VID_ypos_out(VID_ypos_out),
        .line_overrun_out(line_overrun_out)
    );

    typedef struct { int line; logic [23:0] adr; logic [11:0] vec; } exp_t;
    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0, n_err = 0;
    int          req_cnt = 0, ovr_cnt = 0, cur_tag = 0;
    logic        ovr_pending = 1'b0;
    logic [23:0] first_adr, ovr_adr;
    logic [11:0] first_vec;
    logic [23:0] m_ptr [2];
    int          m_w [2], m_sh [2], m_rast = 0;

    always @(negedge CMD_CLK) begin
        if (!reset) begin
            if (line_overrun_out) begin
                ovr_cnt++;
                while (q.size() > 0 && q[0].line != cur_tag) void'(q.pop_front());
                ovr_pending = 1'b1;
            end
            if (read_req_out) begin
                if (req_cnt == 0) begin
                    first_adr = read_adr_out;
                    first_vec = read_line_mem_adr;
                end
                if (ovr_pending) begin
                    ovr_adr     = read_adr_out;
                    ovr_pending = 1'b0;
                end
                req_cnt++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL req_unexpected: got adr %h vec %h, required no request", read_adr_out, read_line_mem_adr);
                end else begin
                    e = q.pop_front();
                    if (read_adr_out !== e.adr || read_line_mem_adr !== e.vec) begin
                        n_err++;
                        $display("FAIL req_data: got adr %h vec %h, required adr %h vec %h",
                                 read_adr_out, read_line_mem_adr, e.adr, e.vec);
                    end
                end
            end
        end
    end

    function automatic int shift_of(input logic [2:0] p);
        return (p == 3'd2) ? 1 : (p == 3'd4) ? 2 : 0;
    endfunction

    task automatic set_layer(input int l, input logic en, input logic [2:0] p, input logic [31:0] a,
                             input logic [15:0] w, input logic [13:0] x, input logic [13:0] y);
        ena[l]        = en;
        pb[l*3 +: 3]  = p;
        mem[l*32 +: 32] = a;
        bw[l*16 +: 16]  = w;
        xp[l*14 +: 14]  = x;
        yp[l*14 +: 14]  = y;
    endtask

    task automatic model_vreset();
        for (int l = 0; l < 2; l++) begin
            longint off;
            m_sh[l]  = shift_of(pb[l*3 +: 3]);
            m_w[l]   = int'(bw[l*16 +: 16]);
            off      = (longint'(bw[l*16 +: 16]) * longint'(yp[l*14 +: 14]) + longint'(xp[l*14 +: 14])) << m_sh[l];
            m_ptr[l] = 24'(longint'(mem[l*32 +: 32]) + off);
        end
        m_rast = 0;
    endtask

    task automatic model_line();
        int   n;
        logic h;
        h       = ~m_rast[0];
        m_rast  = (m_rast + 1) & 4095;
        cur_tag = cur_tag + 1;
        for (int l = 0; l < 2; l++) begin
            if (ena[l]) begin
                n = ((int'(xsize) << m_sh[l]) >> 4) + 1;
                if (n > 512) n = 512;
                for (int k = 0; k < n; k++) begin
                    exp_t x;
                    x.line = cur_tag;
                    x.adr  = m_ptr[l] + 24'(16 * k);
                    x.vec  = (12'(l) << 10) | (12'(h) << 9) | 12'(k);
                    q.push_back(x);
                end
                m_ptr[l] = m_ptr[l] + 24'(m_w[l] << m_sh[l]);
            end
        end
    endtask

    task automatic pulse_hs();
        xena = 1'b1;
        repeat (4) @(posedge CMD_CLK);
        #1 xena = 1'b0;
        repeat (2) @(posedge CMD_CLK);
        #1;
    endtask

    task automatic wait_done();
        int c = 0;
        while (q.size() != 0 && c < 3000) begin
            @(posedge CMD_CLK);
            c++;
        end
        repeat (12) @(posedge CMD_CLK);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL line_timeout: %0d requests still outstanding, required 0", q.size());
        end
    endtask

    task automatic vreset();
        yena = 1'b0;
        repeat (3) @(posedge CMD_CLK);
        #1 req_cnt = 0;
        pulse_hs();
        repeat (8) @(posedge CMD_CLK);
        #1 model_vreset();
        yena = 1'b1;
        repeat (3) @(posedge CMD_CLK);
        #1;
        n_cmp++;
        if (req_cnt !== 0) begin
            n_err++;
            $display("FAIL vreset_reads: got %0d requests, required 0", req_cnt);
        end
    endtask

    task automatic run_line();
        model_line();
        req_cnt = 0;
        pulse_hs();
        wait_done();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CMD_CLK);
        n_cmp++;
        if ({read_req_out, read_adr_out, read_line_mem_adr, VID_xpos_out, VID_ypos_out, line_overrun_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got req %b adr %h vec %h, required all 0", read_req_out, read_adr_out, read_line_mem_adr);
        end
        @(posedge CMD_CLK);
        #1 reset = 1'b0;
    endtask

    task automatic test_single_layer();
        set_layer(0, 1'b1, 3'd4, 32'h1000, 16'd1024, 14'd0, 14'd0);
        set_layer(1, 1'b0, 3'd1, 32'h0, 16'd0, 14'd0, 14'd0);
        xsize = 14'd640;
        vreset();
        run_line();
        n_cmp++;
        if (req_cnt !== 161 || first_adr !== 24'h1000 || first_vec !== 12'h200) begin
            n_err++;
            $display("FAIL single_line1: got cnt %0d adr %h vec %h, required 161 001000 200", req_cnt, first_adr, first_vec);
        end
        run_line();
        n_cmp++;
        if (first_adr !== 24'h2000 || first_vec !== 12'h000) begin
            n_err++;
            $display("FAIL single_line2: got adr %h vec %h, required 002000 000", first_adr, first_vec);
        end
    endtask

    task automatic config_two();
        set_layer(0, 1'b1, 3'd1, 32'h10000, 16'd2048, 14'd0, 14'd0);
        set_layer(1, 1'b1, 3'd2, 32'h40000, 16'd1024, 14'd0, 14'd0);
        xsize = 14'd320;
    endtask

    task automatic test_two_layers();
        config_two();
        vreset();
        for (int i = 0; i < 3; i++) begin
            run_line();
            n_cmp++;
            if (req_cnt !== 62 || VID_ypos_out !== m_rast[0]) begin
                n_err++;
                $display("FAIL two_layers: got cnt %0d ypos %b, required 62 %b", req_cnt, VID_ypos_out, m_rast[0]);
            end
        end
    endtask

    task automatic test_scroll();
        set_layer(0, 1'b1, 3'd2, 32'h8000, 16'd800, 14'd5, 14'd3);
        set_layer(1, 1'b0, 3'd1, 32'h0, 16'd0, 14'd0, 14'd0);
        xsize = 14'd320;
        vreset();
        n_cmp++;
        if (VID_xpos_out[1:0] !== 2'd1) begin
            n_err++;
            $display("FAIL scroll_xpos: got %0d, required 1", VID_xpos_out[1:0]);
        end
        run_line();
        n_cmp++;
        if (first_adr !== 24'h8000 + 24'd4810) begin
            n_err++;
            $display("FAIL scroll_base: got %h, required %h", first_adr, 24'h8000 + 24'd4810);
        end
    endtask

    task automatic test_busy();
        logic done = 1'b0;
        config_two();
        vreset();
        fork
            begin
                run_line();
                done = 1'b1;
            end
            begin
                for (int i = 0; i < 1000 && !done; i++) begin
                    @(posedge CMD_CLK); #1 busy = 1'b1;
                    @(posedge CMD_CLK); #1 busy = 1'b0;
                    @(posedge CMD_CLK); #1;
                end
                busy = 1'b0;
            end
        join
        n_cmp++;
        if (req_cnt !== 62) begin
            n_err++;
            $display("FAIL busy_count: got %0d, required 62", req_cnt);
        end
    endtask

    task automatic test_overrun();
        int c = 0;
        set_layer(0, 1'b1, 3'd2, 32'h20000, 16'd1024, 14'd0, 14'd0);
        set_layer(1, 1'b0, 3'd1, 32'h0, 16'd0, 14'd0, 14'd0);
        xsize = 14'd320;
        vreset();
        ovr_cnt = 0;
        model_line();
        req_cnt = 0;
        pulse_hs();
        while (req_cnt < 10 && c < 500) begin
            @(posedge CMD_CLK);
            c++;
        end
        #1 model_line();
        pulse_hs();
        wait_done();
        n_cmp++;
        if (ovr_cnt !== 1 || ovr_adr !== 24'h20800) begin
            n_err++;
            $display("FAIL overrun: got pulses %0d adr %h, required 1 020800", ovr_cnt, ovr_adr);
        end
    endtask

    task automatic test_disable_and_reset();
        int c = 0;
        config_two();
        vreset();
        ena[1] = 1'b0;
        run_line();
        n_cmp++;
        if (req_cnt !== 21) begin
            n_err++;
            $display("FAIL layer_disable: got %0d, required 21", req_cnt);
        end
        ena[1] = 1'b1;
        model_line();
        req_cnt = 0;
        pulse_hs();
        while (req_cnt < 25 && c < 500) begin
            @(posedge CMD_CLK);
            c++;
        end
        #1 reset = 1'b1;
        @(posedge CMD_CLK);
        @(negedge CMD_CLK);
        q.delete();
        n_cmp++;
        if ({read_req_out, read_adr_out, read_line_mem_adr, VID_xpos_out, VID_ypos_out, line_overrun_out} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_issue: got req %b adr %h vec %h, required all 0", read_req_out, read_adr_out, read_line_mem_adr);
        end
        @(posedge CMD_CLK);
        #1 reset = 1'b0;
        repeat (20) @(posedge CMD_CLK);
        #1;
        n_cmp++;
        if (read_req_out !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: got req %b, required 0", read_req_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_layer();
        test_two_layers();
        test_scroll();
        test_busy();
        test_overrun();
        test_disable_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
